// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and sizing helpers for the parametrised sequence detector
package seq_det_pkg;

  typedef enum logic {
    MODE_OVERLAP    = 1'b0,
    MODE_NONOVERLAP = 1'b1
  } mode_e;

  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter with synchronous clear (clear beats increment)
module seq_match_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - serial pattern detector with care mask, overlap modes and match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter int               COUNT_W     = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(8'b01101001),
  parameter logic [PAT_W-1:0] RST_MASK    = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               en,
  input  logic               mode,
  input  logic               cfg_load,
  input  logic [PAT_W-1:0]   cfg_pattern,
  input  logic [PAT_W-1:0]   cfg_mask,
  input  logic               clr_count,
  output logic               dout,
  output logic [COUNT_W-1:0] match_count,
  output logic               busy
);

  localparam int            FW   = fill_w(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist, hist_d, hist_sh;
  logic [PAT_W-1:0] pattern, pattern_d;
  logic [PAT_W-1:0] mask, mask_d;
  logic [FW-1:0]    fill, fill_d, fill_inc;
  logic             match;

  always_comb begin
    hist_sh   = {hist[PAT_W-2:0], din};
    fill_inc  = (fill == FULL) ? fill : fill + FW'(1);
    match     = en && !cfg_load && (fill_inc == FULL) &&
                (((hist_sh ^ pattern) & mask) == '0);
    hist_d    = hist;
    fill_d    = fill;
    pattern_d = pattern;
    mask_d    = mask;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      hist_d    = '0;
      fill_d    = '0;
    end else if (en) begin
      // Non-overlapping: a match consumes the whole window.
      if (match && (mode_e'(mode) == MODE_NONOVERLAP)) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_sh;
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= RST_PATTERN;
      mask    <= RST_MASK;
      dout    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      hist    <= hist_d;
      fill    <= fill_d;
      pattern <= pattern_d;
      mask    <= mask_d;
      dout    <= match;
      busy    <= (fill_d != '0);
    end
  end

  seq_match_counter #(
    .COUNT_W(COUNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (clr_count),
    .count (match_count)
  );

endmodule
